// File: rtl/blc_cal_sched.sv
// Calibration scheduler for the BLC datapath: issues SOF-aligned calibration strobes,
// supervises completion with a frame-count timeout and smooths the measured black level.
module blc_cal_sched #(
    parameter int unsigned PX_WIDTH       = 10,
    parameter int unsigned FILT_SHIFT     = 2,
    parameter int unsigned TIMEOUT_FRAMES = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sof_i,
    input  logic                en_i,
    input  logic [15:0]         period_i,
    input  logic                sw_req_i,
    input  logic                err_clr_i,
    input  logic                cal_done_i,
    input  logic [PX_WIDTH-1:0] cur_bl_i,
    output logic                cal_stb_o,
    output logic                busy_o,
    output logic [PX_WIDTH-1:0] bl_o,
    output logic                bl_valid_o,
    output logic                timeout_err_o,
    output logic [15:0]         cal_cnt_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_FRAMES + 1);

    typedef enum logic [0:0] {StIdle, StCal} state_e;

    state_e              state_q, state_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                pend_q, pend_d;
    logic                stb_q, stb_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [PX_WIDTH-1:0] bl_q, bl_d;
    logic                valid_q, valid_d;
    logic                first_q, first_d;
    logic                err_q, err_d;
    logic [15:0]         cal_cnt_q, cal_cnt_d;

    logic [16:0]             cnt_inc;
    logic [16:0]             per_m1;
    logic signed [PX_WIDTH:0] diff;
    logic signed [PX_WIDTH:0] step;
    logic [PX_WIDTH-1:0]     filt;

    always_comb begin
        cnt_inc = {1'b0, frame_cnt_q} + 17'd1;
        per_m1  = {1'b0, period_i} - 17'd1;
        // Sum wraps modulo 2^PX_WIDTH; the true result always lies in range.
        diff    = $signed({1'b0, cur_bl_i}) - $signed({1'b0, bl_q});
        step    = diff >>> FILT_SHIFT;
        filt    = bl_q + step[PX_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        pend_d      = pend_q;
        stb_d       = 1'b0;
        tmo_d       = tmo_q;
        bl_d        = bl_q;
        valid_d     = valid_q;
        first_d     = first_q;
        err_d       = err_q;
        cal_cnt_d   = cal_cnt_q;

        if (err_clr_i) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (sof_i && pend_q) begin
                    state_d     = StCal;
                    stb_d       = 1'b1;
                    pend_d      = 1'b0;
                    frame_cnt_d = '0;
                    tmo_d       = '0;
                end else if (sof_i && en_i && (period_i != 16'd0)) begin
                    // ">=" also covers a period shrunk below the running count.
                    if (cnt_inc >= per_m1) begin
                        pend_d      = 1'b1;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = cnt_inc[15:0];
                    end
                end
            end
            StCal: begin
                if (cal_done_i) begin
                    state_d   = StIdle;
                    cal_cnt_d = cal_cnt_q + 16'd1;
                    bl_d      = first_q ? cur_bl_i : filt;
                    valid_d   = 1'b1;
                    first_d   = 1'b0;
                end else if (sof_i) begin
                    if (tmo_q == TmoW'(TIMEOUT_FRAMES - 1)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (sw_req_i) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            pend_q      <= 1'b0;
            stb_q       <= 1'b0;
            tmo_q       <= '0;
            bl_q        <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b1;
            err_q       <= 1'b0;
            cal_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            pend_q      <= pend_d;
            stb_q       <= stb_d;
            tmo_q       <= tmo_d;
            bl_q        <= bl_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            err_q       <= err_d;
            cal_cnt_q   <= cal_cnt_d;
        end
    end

    assign cal_stb_o     = stb_q;
    assign busy_o        = (state_q == StCal);
    assign bl_o          = bl_q;
    assign bl_valid_o    = valid_q;
    assign timeout_err_o = err_q;
    assign cal_cnt_o     = cal_cnt_q;

endmodule

// File: tb/tb_blc_cal_sched.sv
// Directed bench for blc_cal_sched: inputs change just after negedge, outputs sampled at negedge.
module tb_blc_cal_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sof_i = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] period_i = 16'd0;
    logic        sw_req_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic        cal_done_i = 1'b0;
    logic [9:0]  cur_bl_i = 10'd0;
    logic        cal_stb_o;
    logic        busy_o;
    logic [9:0]  bl_o;
    logic        bl_valid_o;
    logic        timeout_err_o;
    logic [15:0] cal_cnt_o;

    int errors = 0;
    int checks = 0;

    blc_cal_sched #(
        .PX_WIDTH      (10),
        .FILT_SHIFT    (2),
        .TIMEOUT_FRAMES(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sof_i        (sof_i),
        .en_i         (en_i),
        .period_i     (period_i),
        .sw_req_i     (sw_req_i),
        .err_clr_i    (err_clr_i),
        .cal_done_i   (cal_done_i),
        .cur_bl_i     (cur_bl_i),
        .cal_stb_o    (cal_stb_o),
        .busy_o       (busy_o),
        .bl_o         (bl_o),
        .bl_valid_o   (bl_valid_o),
        .timeout_err_o(timeout_err_o),
        .cal_cnt_o    (cal_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock cycle with the given pulse inputs; returns at the following negedge.
    task automatic cyc(input logic sof, input logic req, input logic done, input logic clr,
                       input logic [9:0] cur);
        sof_i = sof; sw_req_i = req; cal_done_i = done; err_clr_i = clr; cur_bl_i = cur;
        @(negedge clk_i);
        sof_i = 1'b0; sw_req_i = 1'b0; cal_done_i = 1'b0; err_clr_i = 1'b0; cur_bl_i = 10'd0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        if (cal_stb_o !== 1'b0) begin $display("FAIL reset_stb got %0d exp 0", cal_stb_o); errors++; end
        checks++;
        if (busy_o !== 1'b0) begin $display("FAIL reset_busy got %0d exp 0", busy_o); errors++; end
        checks++;
        if (bl_o !== 10'd0) begin $display("FAIL reset_bl got %0d exp 0", bl_o); errors++; end
        checks++;
        if (bl_valid_o !== 1'b0) begin $display("FAIL reset_valid got %0d exp 0", bl_valid_o); errors++; end
        checks++;
        if (timeout_err_o !== 1'b0) begin $display("FAIL reset_err got %0d exp 0", timeout_err_o); errors++; end
        checks++;
        if (cal_cnt_o !== 16'd0) begin $display("FAIL reset_cnt got %0d exp 0", cal_cnt_o); errors++; end
        checks++;
    endtask

    task automatic test_manual_filter;
        en_i = 1'b0; period_i = 16'd0;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b0) begin $display("FAIL man_nostb_before_sof got %0d exp 0", cal_stb_o); errors++; end
        checks++;
        cyc(1, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b1) begin $display("FAIL man_stb got %0d exp 1", cal_stb_o); errors++; end
        checks++;
        if (busy_o !== 1'b1) begin $display("FAIL man_busy got %0d exp 1", busy_o); errors++; end
        checks++;
        cyc(0, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b0) begin $display("FAIL man_stb_single got %0d exp 0", cal_stb_o); errors++; end
        checks++;
        cyc(0, 0, 1, 0, 10'd64);
        if (bl_o !== 10'd64) begin $display("FAIL filt_first got %0d exp 64", bl_o); errors++; end
        checks++;
        if (bl_valid_o !== 1'b1) begin $display("FAIL filt_valid got %0d exp 1", bl_valid_o); errors++; end
        checks++;
        if (busy_o !== 1'b0) begin $display("FAIL man_busy_low got %0d exp 0", busy_o); errors++; end
        checks++;
        cyc(1, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b0) begin $display("FAIL man_collapsed got %0d exp 0", cal_stb_o); errors++; end
        checks++;
        // Second calibration, with a request arriving while busy.
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b0 || busy_o !== 1'b1) begin
            $display("FAIL man_req_in_cal got stb=%0d busy=%0d exp stb=0 busy=1", cal_stb_o, busy_o);
            errors++;
        end
        checks++;
        cyc(0, 0, 1, 0, 10'd80);
        if (bl_o !== 10'd68) begin $display("FAIL filt_80 got %0d exp 68", bl_o); errors++; end
        checks++;
        if (cal_cnt_o !== 16'd2) begin $display("FAIL man_cnt got %0d exp 2", cal_cnt_o); errors++; end
        checks++;
        cyc(1, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b1) begin $display("FAIL man_served_after_done got %0d exp 1", cal_stb_o); errors++; end
        checks++;
        cyc(0, 0, 1, 0, 10'd67);
        if (bl_o !== 10'd67) begin $display("FAIL filt_67 got %0d exp 67", bl_o); errors++; end
        checks++;
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 10'd68);
        if (bl_o !== 10'd67) begin $display("FAIL filt_68 got %0d exp 67", bl_o); errors++; end
        checks++;
        if (cal_cnt_o !== 16'd4) begin $display("FAIL filt_cnt got %0d exp 4", cal_cnt_o); errors++; end
        checks++;
    endtask

    task automatic test_simultaneous;
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        if (busy_o !== 1'b1) begin $display("FAIL sim_still_busy got %0d exp 1", busy_o); errors++; end
        checks++;
        cyc(1, 0, 1, 0, 10'd71);
        if (busy_o !== 1'b0 || timeout_err_o !== 1'b0) begin
            $display("FAIL sim_done_wins got busy=%0d err=%0d exp busy=0 err=0", busy_o, timeout_err_o);
            errors++;
        end
        checks++;
        if (cal_cnt_o !== 16'd5) begin $display("FAIL sim_cnt got %0d exp 5", cal_cnt_o); errors++; end
        checks++;
        if (bl_o !== 10'd68) begin $display("FAIL sim_bl got %0d exp 68", bl_o); errors++; end
        checks++;
    endtask

    task automatic test_timeout;
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        if (busy_o !== 1'b1 || timeout_err_o !== 1'b0) begin
            $display("FAIL tmo_early got busy=%0d err=%0d exp busy=1 err=0", busy_o, timeout_err_o);
            errors++;
        end
        checks++;
        cyc(1, 0, 0, 0, 0);
        if (timeout_err_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL tmo_fire got err=%0d busy=%0d exp err=1 busy=0", timeout_err_o, busy_o);
            errors++;
        end
        checks++;
        if (bl_o !== 10'd68 || cal_cnt_o !== 16'd5) begin
            $display("FAIL tmo_keep got bl=%0d cnt=%0d exp bl=68 cnt=5", bl_o, cal_cnt_o);
            errors++;
        end
        checks++;
        cyc(0, 0, 0, 1, 0);
        if (timeout_err_o !== 1'b0) begin $display("FAIL tmo_clr got %0d exp 0", timeout_err_o); errors++; end
        checks++;
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        if (timeout_err_o !== 1'b1) begin $display("FAIL tmo_beats_clr got %0d exp 1", timeout_err_o); errors++; end
        checks++;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 10'd500);
        if (bl_o !== 10'd68 || cal_cnt_o !== 16'd5 || timeout_err_o !== 1'b0) begin
            $display("FAIL done_outside_cal got bl=%0d cnt=%0d err=%0d exp bl=68 cnt=5 err=0",
                     bl_o, cal_cnt_o, timeout_err_o);
            errors++;
        end
        checks++;
    endtask

    task automatic test_periodic;
        en_i = 1'b1; period_i = 16'd3;
        for (int r = 0; r < 3; r++) begin
            cyc(1, 0, 0, 0, 0);
            if (cal_stb_o !== 1'b0) begin $display("FAIL per_sof1 r%0d got %0d exp 0", r, cal_stb_o); errors++; end
            checks++;
            cyc(0, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0);
            if (cal_stb_o !== 1'b0) begin $display("FAIL per_sof2 r%0d got %0d exp 0", r, cal_stb_o); errors++; end
            checks++;
            cyc(0, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0);
            if (cal_stb_o !== 1'b1 || busy_o !== 1'b1) begin
                $display("FAIL per_stb r%0d got stb=%0d busy=%0d exp 1 1", r, cal_stb_o, busy_o);
                errors++;
            end
            checks++;
            for (int i = 0; i < 9; i++) begin
                cyc(0, 0, 0, 0, 0);
                if (busy_o !== 1'b1 || cal_stb_o !== 1'b0) begin
                    $display("FAIL per_busy r%0d c%0d got busy=%0d stb=%0d exp 1 0", r, i, busy_o, cal_stb_o);
                    errors++;
                end
                checks++;
            end
            cyc(0, 0, 1, 0, 10'd68);
            if (busy_o !== 1'b0) begin $display("FAIL per_busy_low r%0d got %0d exp 0", r, busy_o); errors++; end
            checks++;
            if (cal_cnt_o !== 16'(6 + r)) begin
                $display("FAIL per_cnt r%0d got %0d exp %0d", r, cal_cnt_o, 6 + r);
                errors++;
            end
            checks++;
        end
        // Shrinking the period below the running count triggers on the next sof.
        period_i = 16'd6;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        period_i = 16'd2;
        cyc(1, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b0) begin $display("FAIL per_shrink_pend got %0d exp 0", cal_stb_o); errors++; end
        checks++;
        cyc(1, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b1) begin $display("FAIL per_shrink_stb got %0d exp 1", cal_stb_o); errors++; end
        checks++;
        cyc(0, 0, 1, 0, 10'd68);
        en_i = 1'b0;
        if (cal_cnt_o !== 16'd9) begin $display("FAIL per_shrink_cnt got %0d exp 9", cal_cnt_o); errors++; end
        checks++;
    endtask

    task automatic test_reset_mid_cal;
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        if (busy_o !== 1'b1) begin $display("FAIL rst_pre_busy got %0d exp 1", busy_o); errors++; end
        checks++;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc(0, 0, 1, 0, 10'd100);
        if (busy_o !== 1'b0 || bl_o !== 10'd0 || bl_valid_o !== 1'b0 || cal_cnt_o !== 16'd0
            || timeout_err_o !== 1'b0 || cal_stb_o !== 1'b0) begin
            $display("FAIL rst_abort got busy=%0d bl=%0d valid=%0d cnt=%0d err=%0d stb=%0d exp all 0",
                     busy_o, bl_o, bl_valid_o, cal_cnt_o, timeout_err_o, cal_stb_o);
            errors++;
        end
        checks++;
        cyc(1, 0, 0, 0, 0);
        if (cal_stb_o !== 1'b0) begin $display("FAIL rst_no_pend got %0d exp 0", cal_stb_o); errors++; end
        checks++;
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 10'd30);
        if (bl_o !== 10'd30 || bl_valid_o !== 1'b1 || cal_cnt_o !== 16'd1) begin
            $display("FAIL rst_first_sample got bl=%0d valid=%0d cnt=%0d exp 30 1 1",
                     bl_o, bl_valid_o, cal_cnt_o);
            errors++;
        end
        checks++;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_manual_filter();
        test_simultaneous();
        test_timeout();
        test_periodic();
        test_reset_mid_cal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blc_cal_sched.md
Name: blc_cal_sched

Overview:
- Calibration scheduler for the black level correction datapath.
- Issues single-cycle calibration strobes aligned to frame start: periodic every N frames, or on a software request.
- Waits for datapath completion with a frame-count timeout, then exponentially smooths the measured black level.
- Sits between the BLC CSR block (request/config) and the BLC datapath (cal_stb/cal_done/cur_bl).

Parameters:
- PX_WIDTH, 10, width of black level value.
- FILT_SHIFT, 2, smoothing shift k; bl += (cur - bl) >>> k; 0 = no smoothing.
- TIMEOUT_FRAMES, 4, SOFs tolerated in CAL before timeout; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- sof_i  in  1  start-of-frame pulse, one cycle
- en_i  in  1  enable periodic calibration
- period_i  in  16  frames between periodic calibrations; 0 = periodic off
- sw_req_i  in  1  software calibration request pulse
- err_clr_i  in  1  clear timeout_err_o
- cal_done_i  in  1  datapath calibration finished pulse
- cur_bl_i  in  PX_WIDTH  datapath measured black level, valid with cal_done_i
- cal_stb_o  out  1  calibration start pulse to datapath
- busy_o  out  1  high in CAL state
- bl_o  out  PX_WIDTH  smoothed black level
- bl_valid_o  out  1  high once the first calibration has completed
- timeout_err_o  out  1  sticky timeout flag
- cal_cnt_o  out  16  completed calibrations, wraps at 2^16

Behaviour:
- Reset: all outputs 0, frame counter 0, pending flag 0, state IDLE, first-sample flag set. Reset mid-CAL aborts silently; no strobe or done is carried over.
- Frame counter: in IDLE with en_i=1 and period_i!=0, increments on each sof_i. When it reaches period_i-1, the pending flag is set on that sof and the counter clears. The counter holds when en_i=0 or period_i=0, and clears on entry to CAL.
- sw_req_i sets pending in any state, regardless of en_i. Multiple requests collapse to one pending flag.
- IDLE -> CAL on a sof_i cycle when pending is already set before that cycle.
  - cal_stb_o pulses 1 cycle, in the cycle after that sof_i.
  - pending clears; busy_o goes high together with cal_stb_o.
  - A pending flag set on the same sof_i cycle is served at the next sof.
- CAL, on cal_done_i:
  - capture cur_bl_i, increment cal_cnt_o, go to IDLE; busy_o low the next cycle.
  - Filter (first sample): bl_o <= cur_bl_i, bl_valid_o <= 1.
  - Filter (otherwise): diff = signed(PX_WIDTH+1) cur_bl_i - bl_o; bl_o <= bl_o + (diff >>> FILT_SHIFT), arithmetic shift rounding toward minus infinity. The result is always within [0, 2^PX_WIDTH-1]; no saturation needed.
- CAL, timeout counter:
  - cleared on entry to CAL; increments on sof_i without cal_done_i.
  - On the sof that makes it reach TIMEOUT_FRAMES: timeout_err_o <= 1, go to IDLE, bl_o unchanged.
- sof_i and cal_done_i in the same cycle in CAL: done wins, no timeout increment.
- cal_done_i outside CAL is ignored.
- sw_req_i during CAL sets pending; it is served on a later sof after returning to IDLE.
- err_clr_i clears timeout_err_o. A same-cycle timeout wins (flag stays 1).
- period_i changes take effect immediately. If the counter is already >= period_i-1, pending is set at the next sof.

Test Plan:
- Periodic: en_i=1, period_i=3, done returned 10 cycles after each strobe → cal_stb_o 1 cycle after every 3rd sof; cal_cnt_o increments; busy_o is high exactly from strobe to done.
- Filter, FILT_SHIFT=2:
  - first cur_bl=64 → bl_o=64, bl_valid_o=1.
  - then cur=80 → 68; then cur=67 → 67 (diff -1>>>2 = -1); then cur=68 → 67 (diff 1>>>2 = 0).
- Timeout, TIMEOUT_FRAMES=4:
  - strobe issued, no done, 4 sofs → timeout_err_o=1 on the 4th sof, back to IDLE, bl_o unchanged.
  - err_clr_i → flag 0.
  - err_clr_i in the same cycle as a new timeout → flag stays 1.
- Manual: en_i=0, sw_req_i pulsed twice before a sof → exactly one strobe after the next sof. sw_req_i during CAL → second strobe on the first sof after done.
- Simultaneous: in CAL, sof_i and cal_done_i in the same cycle with timeout count at 3 → done accepted, cal_cnt_o+1, no error.
- Reset: rst_i asserted in CAL, then cal_done_i → ignored; all outputs 0; the next calibration takes the first-sample path.
